// File: rtl/osd_blend_window_pkg.sv
// Shared definitions for the OSD window overlay: mix mode codes and frame FSM states.
package osd_pkg;

   localparam logic [1:0] OSD_REPLACE = 2'd0;
   localparam logic [1:0] OSD_AVERAGE = 2'd1;
   localparam logic [1:0] OSD_KEY     = 2'd2;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      VBLANK  = 2'd1,
      ACTIVE  = 2'd2
   } osd_state_e;

endpackage

// File: rtl/osd_blend_window_if.sv
// Video stream, window configuration and OSD source signals of the overlay block.
interface osd_blend_window_if #(
   parameter int C_bits  = 8,
   parameter int C_xbits = 11,
   parameter int C_ybits = 11
);
   logic [C_bits-1:0]   i_r, i_g, i_b;
   logic                i_hsync, i_vsync, i_blank;
   logic                i_osd_en;
   logic [1:0]          i_mode, i_zoom;
   logic [C_xbits-1:0]  i_x_start, i_width;
   logic [C_ybits-1:0]  i_y_start, i_height;
   logic [3*C_bits-1:0] i_key;
   logic [C_bits-1:0]   i_osd_r, i_osd_g, i_osd_b;
   logic [C_xbits-1:0]  o_osd_x;
   logic [C_ybits-1:0]  o_osd_y;
   logic                o_osd_req;
   logic [C_bits-1:0]   o_r, o_g, o_b;
   logic                o_hsync, o_vsync, o_blank, o_frame;

   modport master (
      output i_r, i_g, i_b, i_hsync, i_vsync, i_blank, i_osd_en, i_mode, i_zoom,
             i_x_start, i_width, i_y_start, i_height, i_key, i_osd_r, i_osd_g, i_osd_b,
      input  o_osd_x, o_osd_y, o_osd_req, o_r, o_g, o_b, o_hsync, o_vsync, o_blank, o_frame
   );

   modport slave (
      input  i_r, i_g, i_b, i_hsync, i_vsync, i_blank, i_osd_en, i_mode, i_zoom,
             i_x_start, i_width, i_y_start, i_height, i_key, i_osd_r, i_osd_g, i_osd_b,
      output o_osd_x, o_osd_y, o_osd_req, o_r, o_g, o_b, o_hsync, o_vsync, o_blank, o_frame
   );
endinterface

// File: rtl/osd_blend_window_delay.sv
// Enable-gated shift register of D stages; D=0 is a plain wire.
module osd_delay #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   generate
      if (D == 0) begin : g_pass
         assign dout = din;
      end else begin : g_sr
         logic [W-1:0] sr_r [D];

         // shift one stage per enabled cycle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) sr_r[i] <= {W{1'b0}};
            end else if (ena) begin
               sr_r[0] <= din;
               for (int i = 1; i < D; i++) sr_r[i] <= sr_r[i-1];
            end
         end

         assign dout = sr_r[D-1];
      end
   endgenerate
endmodule

// File: rtl/osd_blend_window.sv
// OSD window overlay: frame FSM, screen counters, vsync-latched window config,
// OSD request stage, latency-matching delay and colour mixer.
module osd_blend_window
   import osd_pkg::*;
#(
   parameter int C_bits  = 8,
   parameter int C_xbits = 11,
   parameter int C_ybits = 11,
   parameter int C_lat   = 2
) (
   input  logic clk_pixel,
   input  logic rst_n,
   input  logic clk_pixel_ena,
   osd_blend_window_if.slave bus
);
   localparam int DW = 3*C_bits + 4;
   localparam logic [C_xbits-1:0] X_ONE = {{(C_xbits-1){1'b0}}, 1'b1};
   localparam logic [C_xbits-1:0] X_MAX = {C_xbits{1'b1}};
   localparam logic [C_ybits-1:0] Y_ONE = {{(C_ybits-1){1'b0}}, 1'b1};
   localparam logic [C_ybits-1:0] Y_MAX = {C_ybits{1'b1}};

   osd_state_e          state_r, state_nxt_s;
   logic                vsync_d_r, hsync_d_r, blank_d_r;
   logic                vs_rise_s, hs_rise_s, bl_rise_s;
   logic [C_xbits-1:0]  x_r, xs_r, w_r, dx_s, osd_x_r;
   logic [C_ybits-1:0]  y_r, ys_r, h_r, dy_s, osd_y_r;
   logic [C_xbits:0]    x_end_s;
   logic [C_ybits:0]    y_end_s;
   logic [1:0]          mode_r, zoom_r;
   logic [3*C_bits-1:0] key_r;
   logic                hit_s, osd_req_r, key_hit_s;
   logic [DW-1:0]       dly_in_s, dly_out_s;
   logic [C_bits-1:0]   vid_r_s, vid_g_s, vid_b_s;
   logic                vid_hs_s, vid_vs_s, vid_bl_s, vid_hit_s;
   logic [C_bits:0]     sum_r_s, sum_g_s, sum_b_s;
   logic [C_bits-1:0]   mix_r_s, mix_g_s, mix_b_s;
   logic [C_bits-1:0]   out_r_r, out_g_r, out_b_r;
   logic                out_hs_r, out_vs_r, out_bl_r, frame_r;

   assign vs_rise_s = bus.i_vsync & ~vsync_d_r;
   assign hs_rise_s = bus.i_hsync & ~hsync_d_r;
   assign bl_rise_s = bus.i_blank & ~blank_d_r;

   // frame FSM next state; the first unblanked pixel after vblank already counts as ACTIVE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         WAIT_VS: if (vs_rise_s) state_nxt_s = VBLANK; else state_nxt_s = WAIT_VS;
         VBLANK:  if (vs_rise_s) state_nxt_s = VBLANK;
                  else if (!bus.i_blank) state_nxt_s = ACTIVE;
                  else state_nxt_s = VBLANK;
         ACTIVE:  if (vs_rise_s) state_nxt_s = VBLANK; else state_nxt_s = ACTIVE;
         default: state_nxt_s = WAIT_VS;
      endcase
   end

   // window hit test; end coordinates carry an extra bit so the window clips instead of wrapping
   always_comb begin
      x_end_s = {1'b0, xs_r} + {1'b0, w_r};
      y_end_s = {1'b0, ys_r} + {1'b0, h_r};
      dx_s    = x_r - xs_r;
      dy_s    = y_r - ys_r;
      hit_s   = (state_nxt_s == ACTIVE) && !bus.i_blank &&
                (x_r >= xs_r) && ({1'b0, x_r} < x_end_s) &&
                (y_r >= ys_r) && ({1'b0, y_r} < y_end_s);
   end

   // FSM state, sync edge history, saturating screen counters and vsync-latched config
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= WAIT_VS;
         vsync_d_r <= 1'b0;
         hsync_d_r <= 1'b0;
         blank_d_r <= 1'b0;
         x_r       <= {C_xbits{1'b0}};
         y_r       <= {C_ybits{1'b0}};
         mode_r    <= 2'd0;
         zoom_r    <= 2'd0;
         xs_r      <= {C_xbits{1'b0}};
         w_r       <= {C_xbits{1'b0}};
         ys_r      <= {C_ybits{1'b0}};
         h_r       <= {C_ybits{1'b0}};
         key_r     <= {(3*C_bits){1'b0}};
      end else if (clk_pixel_ena) begin
         state_r   <= state_nxt_s;
         vsync_d_r <= bus.i_vsync;
         hsync_d_r <= bus.i_hsync;
         blank_d_r <= bus.i_blank;
         if (hs_rise_s) x_r <= {C_xbits{1'b0}};
         else if (!bus.i_blank && (x_r != X_MAX)) x_r <= x_r + X_ONE;
         if (vs_rise_s) y_r <= {C_ybits{1'b0}};
         else if (bl_rise_s && (state_r == ACTIVE) && (y_r != Y_MAX)) y_r <= y_r + Y_ONE;
         if (vs_rise_s) begin
            mode_r <= bus.i_mode;
            zoom_r <= bus.i_zoom;
            xs_r   <= bus.i_x_start;
            w_r    <= bus.i_width;
            ys_r   <= bus.i_y_start;
            h_r    <= bus.i_height;
            key_r  <= bus.i_key;
         end
      end
   end

   // OSD request stage; coordinates stay 0 outside the window
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         osd_x_r   <= {C_xbits{1'b0}};
         osd_y_r   <= {C_ybits{1'b0}};
         osd_req_r <= 1'b0;
      end else if (clk_pixel_ena) begin
         osd_x_r   <= hit_s ? (dx_s >> zoom_r) : {C_xbits{1'b0}};
         osd_y_r   <= hit_s ? (dy_s >> zoom_r) : {C_ybits{1'b0}};
         osd_req_r <= hit_s;
      end
   end

   assign dly_in_s = {bus.i_r, bus.i_g, bus.i_b, bus.i_hsync, bus.i_vsync, bus.i_blank,
                      hit_s & bus.i_osd_en};

   osd_delay #(.W(DW), .D(C_lat + 1)) u_delay (
      .clk  (clk_pixel),
      .rst_n(rst_n),
      .ena  (clk_pixel_ena),
      .din  (dly_in_s),
      .dout (dly_out_s)
   );

   assign {vid_r_s, vid_g_s, vid_b_s, vid_hs_s, vid_vs_s, vid_bl_s, vid_hit_s} = dly_out_s;

   // colour mixer on the latency-aligned video and OSD pixel
   always_comb begin
      sum_r_s   = {1'b0, vid_r_s} + {1'b0, bus.i_osd_r};
      sum_g_s   = {1'b0, vid_g_s} + {1'b0, bus.i_osd_g};
      sum_b_s   = {1'b0, vid_b_s} + {1'b0, bus.i_osd_b};
      key_hit_s = ({bus.i_osd_r, bus.i_osd_g, bus.i_osd_b} == key_r);
      mix_r_s   = vid_r_s;
      mix_g_s   = vid_g_s;
      mix_b_s   = vid_b_s;
      if (vid_hit_s) begin
         case (mode_r)
            OSD_REPLACE: begin
               mix_r_s = bus.i_osd_r; mix_g_s = bus.i_osd_g; mix_b_s = bus.i_osd_b;
            end
            OSD_AVERAGE: begin
               mix_r_s = sum_r_s[C_bits:1]; mix_g_s = sum_g_s[C_bits:1]; mix_b_s = sum_b_s[C_bits:1];
            end
            OSD_KEY: begin
               if (key_hit_s) begin
                  mix_r_s = vid_r_s; mix_g_s = vid_g_s; mix_b_s = vid_b_s;
               end else begin
                  mix_r_s = bus.i_osd_r; mix_g_s = bus.i_osd_g; mix_b_s = bus.i_osd_b;
               end
            end
            default: begin
               mix_r_s = bus.i_osd_r; mix_g_s = bus.i_osd_g; mix_b_s = bus.i_osd_b;
            end
         endcase
      end else begin
         mix_r_s = vid_r_s; mix_g_s = vid_g_s; mix_b_s = vid_b_s;
      end
   end

   // output register: mixed colour, aligned timing and frame pulse
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         out_r_r  <= {C_bits{1'b0}};
         out_g_r  <= {C_bits{1'b0}};
         out_b_r  <= {C_bits{1'b0}};
         out_hs_r <= 1'b0;
         out_vs_r <= 1'b0;
         out_bl_r <= 1'b0;
         frame_r  <= 1'b0;
      end else if (clk_pixel_ena) begin
         out_r_r  <= mix_r_s;
         out_g_r  <= mix_g_s;
         out_b_r  <= mix_b_s;
         out_hs_r <= vid_hs_s;
         out_vs_r <= vid_vs_s;
         out_bl_r <= vid_bl_s;
         frame_r  <= vs_rise_s;
      end
   end

   assign bus.o_osd_x   = osd_x_r;
   assign bus.o_osd_y   = osd_y_r;
   assign bus.o_osd_req = osd_req_r;
   assign bus.o_r       = out_r_r;
   assign bus.o_g       = out_g_r;
   assign bus.o_b       = out_b_r;
   assign bus.o_hsync   = out_hs_r;
   assign bus.o_vsync   = out_vs_r;
   assign bus.o_blank   = out_bl_r;
   assign bus.o_frame   = frame_r;
endmodule
